// File: rtl/digit_serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, with borrow-out, zero and signed-overflow flags.
// Optional unsigned saturation (clamp to 0 on final borrow) is enabled by defining SUB_SAT_EN.
module digit_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d, brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic             bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;
    logic [DIGIT:0]   dsub_s;
    logic [WIDTH-1:0] fin_s;

    // Shared digit subtractor; operands are shifted right so the active digit is always at the bottom.
    always_comb begin
        dsub_s = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_q};
    end

    // Final result value, optionally clamped on a final borrow.
    always_comb begin
`ifdef SUB_SAT_EN
        if (brw_q) begin
            fin_s = {WIDTH{1'b0}};
        end else begin
            fin_s = res_q;
        end
`else
        fin_s = res_q;
`endif
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    brw_d   = bin;
                    cnt_d   = {CW{1'b0}};
                    res_d   = {WIDTH{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                brw_d = dsub_s[DIGIT];
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                // Result digits enter at the top and drift down, landing LSB-first in place.
                res_d = (res_q >> DIGIT) | (WIDTH'(dsub_s[DIGIT-1:0]) << (WIDTH - DIGIT));
                if (cnt_q == CW'(NSTEP - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                diff_d  = fin_s;
                bout_d  = brw_q;
                zero_d  = (fin_s == {WIDTH{1'b0}});
                ovf_d   = (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_RUN);
        done_d  = (state_q == S_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            brw_q   <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign diff  = diff_q;
    assign bout  = bout_q;
    assign zero  = zero_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Bench for digit_serial_subtractor: five instances (DIGIT = 1,2,4,8,16, WIDTH = 16) checked
// against an arithmetic a - b - bin model; honours SUB_SAT_EN when defined.
module tb_digit_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_s, b_s;
    logic        bin_s;
    logic        start_v [5];
    logic        ready_v [5];
    logic        busy_v  [5];
    logic        done_v  [5];
    logic [15:0] diff_v  [5];
    logic        bout_v  [5];
    logic        zero_v  [5];
    logic        ovf_v   [5];

    int tests_run = 0;
    int fails     = 0;
    int cyc       = 0;
    int done_cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        digit_serial_subtractor #(.WIDTH(16), .DIGIT(1 << g)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_v[g]),
            .a     (a_s),
            .b     (b_s),
            .bin   (bin_s),
            .ready (ready_v[g]),
            .busy  (busy_v[g]),
            .done  (done_v[g]),
            .diff  (diff_v[g]),
            .bout  (bout_v[g]),
            .zero  (zero_v[g]),
            .ovf   (ovf_v[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run one operation on instance k starting at a negedge; returns at the negedge of the done cycle.
    task automatic do_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                         input logic binv, input string tag);
        int          n;
        int          lat;
        logic [16:0] full;
        int          sd;
        logic [15:0] e_diff;
        logic        e_bout, e_ovf;
        n    = 16 / (1 << k);
        full = {1'b0, av} - {1'b0, bv} - {16'd0, binv};
        sd   = int'($signed(av)) - int'($signed(bv)) - int'(binv);
        e_bout = full[16];
        e_ovf  = (sd > 32767) || (sd < -32768);
        e_diff = full[15:0];
`ifdef SUB_SAT_EN
        if (e_bout) e_diff = 16'h0000;
`endif
        chk({tag, ".ready"}, {31'd0, ready_v[k]}, 32'd1);
        a_s = av; b_s = bv; bin_s = binv; start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        chk({tag, ".busy"}, {31'd0, busy_v[k]}, 32'd1);
        lat = 0;
        for (int c = 1; c <= n + 10 && lat == 0; c++) begin
            @(negedge clk);
            if (done_v[k]) lat = c;
        end
        done_cyc = cyc;
        chk({tag, ".latency"}, lat, n + 1);
        chk({tag, ".diff"}, {16'd0, diff_v[k]}, {16'd0, e_diff});
        chk({tag, ".bout"}, {31'd0, bout_v[k]}, {31'd0, e_bout});
        chk({tag, ".zero"}, {31'd0, zero_v[k]}, {31'd0, (e_diff == 16'h0000)});
        chk({tag, ".ovf"}, {31'd0, ovf_v[k]}, {31'd0, e_ovf});
    endtask

    initial begin
        int prev;
        int extra;
        logic got;
        rst = 1'b1; a_s = 16'h0000; b_s = 16'h0000; bin_s = 1'b0;
        for (int k = 0; k < 5; k++) start_v[k] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rst%0d.ready", k), {31'd0, ready_v[k]}, 32'd1);
            chk($sformatf("rst%0d.busy", k), {31'd0, busy_v[k]}, 32'd0);
            chk($sformatf("rst%0d.done", k), {31'd0, done_v[k]}, 32'd0);
            chk($sformatf("rst%0d.flags", k),
                {13'd0, diff_v[k], bout_v[k], zero_v[k], ovf_v[k]}, 32'd0);
        end

        do_op(2, 16'h1234, 16'h0234, 1'b0, "t1");
        chk("t1.const", {16'd0, diff_v[2]}, 32'h1000);
        do_op(2, 16'h0000, 16'h0001, 1'b0, "t2");
        do_op(2, 16'h8000, 16'h0001, 1'b0, "t3a");
        chk("t3a.const", {16'd0, diff_v[2], ovf_v[2], 15'd0}, {16'h7FFF, 1'b1, 15'd0});
        do_op(2, 16'h7FFF, 16'hFFFF, 1'b0, "t3b");
        do_op(2, 16'h0005, 16'h0004, 1'b1, "t4a");
        chk("t4a.const", {16'd0, diff_v[2]}, 32'h0000);
        do_op(2, 16'h0000, 16'h0000, 1'b1, "t4b");

        // start during RUN must be ignored
        @(negedge clk);
        a_s = 16'h00F0; b_s = 16'h000F; bin_s = 1'b0; start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        @(negedge clk);
        chk("t5.ready_run", {31'd0, ready_v[2]}, 32'd0);
        a_s = 16'hFFFF; b_s = 16'h0001; bin_s = 1'b1; start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (done_v[2]) got = 1'b1;
        end
        chk("t5.done_seen", {31'd0, got}, 32'd1);
        chk("t5.diff", {16'd0, diff_v[2]}, 32'h00E1);
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done_v[2]) extra++;
        end
        chk("t5.no_queue", extra, 0);
        chk("t5.ready_after", {31'd0, ready_v[2]}, 32'd1);

        // asynchronous reset mid-RUN
        a_s = 16'h1234; b_s = 16'h0001; bin_s = 1'b0; start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5.rst_ready", {31'd0, ready_v[2]}, 32'd1);
        chk("t5.rst_busy", {31'd0, busy_v[2]}, 32'd0);
        chk("t5.rst_outs", {13'd0, diff_v[2], bout_v[2], zero_v[2], ovf_v[2]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(2, 16'hABCD, 16'h1234, 1'b1, "t5.after_rst");

        // random sweep over all DIGIT values, back-to-back
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            prev = 0;
            for (int i = 0; i < 1000; i++) begin
                do_op(k, 16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)),
                      $sformatf("rnd_d%0d_%0d", 1 << k, i));
                if (i > 0) chk($sformatf("rnd_d%0d_%0d.spacing", 1 << k, i),
                               done_cyc - prev, (16 / (1 << k)) + 2);
                prev = done_cyc;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
